// File: rtl/mux_scan_if.sv
// -----------------------------------------------------------------------------
// mux_scan_if
// Groups the signals between the system controller, the 4:1 mux and the scan
// controller.
//   start      : request a scan (controller -> scan ctrl)
//   ch_en[3:0] : channel enable mask, bit k enables mux input k
//   continuous : re-scan automatically after each done
//   abort      : terminate the scan in progress
//   y          : mux output fed back to the scan controller
//   sel[1:0]   : mux select driven by the scan controller
//   sel_valid  : sel is driving an active scan channel
//   busy       : a scan is in progress (dwell or done)
//   done       : one-cycle pulse, result updated this cycle
//   err        : one-cycle pulse, start accepted with an empty mask
//   result[3:0]: packed samples, disabled channels read 0
// Modports: master = system controller / mux side, slave = scan controller.
// -----------------------------------------------------------------------------
interface mux_scan_if;
  logic       start;
  logic [3:0] ch_en;
  logic       continuous;
  logic       abort;
  logic       y;
  logic [1:0] sel;
  logic       sel_valid;
  logic       busy;
  logic       done;
  logic       err;
  logic [3:0] result;

  modport master (
    output start, ch_en, continuous, abort, y,
    input  sel, sel_valid, busy, done, err, result
  );

  modport slave (
    input  start, ch_en, continuous, abort, y,
    output sel, sel_valid, busy, done, err, result
  );
endinterface

// File: rtl/mux_scan_ctrl.sv
// -----------------------------------------------------------------------------
// mux_scan_ctrl
// Scan controller placed upstream of a 4:1 mux. It drives the mux select,
// dwells DWELL cycles on every enabled channel in ascending order, samples the
// mux output on the last dwell cycle and packs the samples into a 4-bit result.
// Single-shot or continuous round-robin scanning, start/busy/done handshake.
//
// Ports:
//   clk   : system clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : mux_scan_if.slave (start, ch_en, continuous, abort, y in;
//           sel, sel_valid, busy, done, err, result out)
//
// Parameters:
//   DWELL   : cycles spent on each enabled channel (1..15, 3..15 with MAJ)
//   DWELL_W : dwell counter width, must hold DWELL-1
//
// Build option:
//   MUX_SCAN_MAJ_EN : when defined, each channel bit is the majority of the
//                     samples taken on the last three dwell cycles.
// -----------------------------------------------------------------------------
module mux_scan_ctrl #(
  parameter int DWELL   = 4,
  parameter int DWELL_W = 4
) (
  input logic       clk,
  input logic       rst_n,
  mux_scan_if.slave bus
);

  typedef enum logic [1:0] {S_IDLE, S_DWELL, S_DONE} state_e;

  localparam logic [DWELL_W-1:0] CNT_LAST = DWELL_W'(DWELL - 1);

  // Index of the lowest set bit; 0 for an empty mask (callers guard that case).
  function automatic logic [1:0] lowest_en(input logic [3:0] m);
    lowest_en = 2'd0;
    for (int k = 3; k >= 0; k--) begin
      if (m[k]) lowest_en = 2'(k);
    end
  endfunction

  state_e             state_q, state_d;
  logic [1:0]         ch_q, ch_d;
  logic [DWELL_W-1:0] cnt_q, cnt_d;
  logic [3:0]         mask_q, mask_d;
  logic [3:0]         shadow_q, shadow_d;
  logic [3:0]         result_q, result_d;
  logic               err_q, err_d;

  logic       dwell_end;
  logic [3:0] above;
  logic       sample;

  assign dwell_end = (state_q == S_DWELL) && (cnt_q == CNT_LAST);
  // Enabled channels strictly above the current one; disabled ones are skipped.
  assign above     = mask_q & (4'b1110 << ch_q);

`ifdef MUX_SCAN_MAJ_EN
  localparam logic [DWELL_W-1:0] CNT_MAJ0 = DWELL_W'(DWELL - 3);
  localparam logic [DWELL_W-1:0] CNT_MAJ1 = DWELL_W'(DWELL - 2);

  logic [1:0] maj_q, maj_d;

  always_comb begin
    maj_d = maj_q;
    if (state_q == S_DWELL) begin
      if (cnt_q == CNT_MAJ0) maj_d[0] = bus.y;
      if (cnt_q == CNT_MAJ1) maj_d[1] = bus.y;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) maj_q <= 2'b00;
    else        maj_q <= maj_d;
  end

  assign sample = (maj_q[0] & maj_q[1]) | (maj_q[0] & bus.y) | (maj_q[1] & bus.y);
`else
  assign sample = bus.y;
`endif

  // FSM: state register
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of process ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // FSM: next state. abort outranks everything except start in IDLE.
  // NOTE: every comb output gets a default first so no path infers a latch.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (bus.start && (bus.ch_en != 4'b0000)) state_d = S_DWELL;
      S_DWELL: begin
        if (bus.abort)                            state_d = S_IDLE;
        else if (dwell_end && (above == 4'b0000)) state_d = S_DONE;
      end
      S_DONE:  begin
        if (bus.abort)           state_d = S_IDLE;
        else if (bus.continuous) state_d = S_DWELL;
        else                     state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // FSM: outputs decoded from the registered state
  always_comb begin
    bus.sel       = (state_q == S_IDLE) ? 2'b00 : ch_q;
    bus.sel_valid = (state_q == S_DWELL);
    bus.busy      = (state_q != S_IDLE);
    bus.done      = (state_q == S_DONE);
  end

  assign bus.err    = err_q;
  assign bus.result = result_q;

  // Datapath next-state: channel pointer, dwell counter, mask, samples.
  always_comb begin
    ch_d     = ch_q;
    cnt_d    = cnt_q;
    mask_d   = mask_q;
    shadow_d = shadow_q;
    result_d = result_q;
    err_d    = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          if (bus.ch_en == 4'b0000) begin
            err_d = 1'b1;
          end else begin
            mask_d   = bus.ch_en;
            shadow_d = 4'b0000;
            ch_d     = lowest_en(bus.ch_en);
            cnt_d    = '0;
          end
        end
      end
      S_DWELL: begin
        if (!bus.abort) begin
          if (dwell_end) begin
            shadow_d[ch_q] = sample;
            if (above != 4'b0000) begin
              ch_d  = lowest_en(above);
              cnt_d = '0;
            end else begin
              // Publish including the sample captured on this same edge.
              result_d = shadow_d;
            end
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      S_DONE: begin
        // Continuous rescans reuse the mask latched at the original start.
        if (!bus.abort && bus.continuous) begin
          ch_d     = lowest_en(mask_q);
          cnt_d    = '0;
          shadow_d = 4'b0000;
        end
      end
      default: ;
    endcase
  end

  // NOTE: all datapath registers are few and control-relevant, so every one
  // of them is reset; there is no storage array that could skip reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ch_q     <= 2'b00;
      cnt_q    <= '0;
      mask_q   <= 4'b0000;
      shadow_q <= 4'b0000;
      result_q <= 4'b0000;
      err_q    <= 1'b0;
    end else begin
      ch_q     <= ch_d;
      cnt_q    <= cnt_d;
      mask_q   <= mask_d;
      shadow_q <= shadow_d;
      result_q <= result_d;
      err_q    <= err_d;
    end
  end

endmodule

// File: tb/tb_mux_scan_ctrl.sv
// -----------------------------------------------------------------------------
// tb_mux_scan_ctrl
// Self-checking bench for mux_scan_ctrl. A behavioural 4:1 mux drives y from
// mux_i[sel]. Expected sel sequences, done cycles and results come from the
// scan rules: enabled channels in ascending order, DWELL cycles each, done in
// cycle N*DWELL+1, result = mux inputs masked by the enable mask.
// -----------------------------------------------------------------------------
module tb_mux_scan_ctrl;

  localparam int DWELL = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] mux_i = 4'b0000;
  logic       glitch = 1'b0;

  int n_tests = 0;
  int n_fail  = 0;

  mux_scan_if bus ();

  assign bus.y = mux_i[bus.sel] ^ glitch;

  mux_scan_ctrl #(.DWELL(DWELL), .DWELL_W(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] ch_en;
    logic [3:0] mux_in;
    logic [3:0] exp_result;
  } vec_t;

  vec_t vecs [6];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // {err, sel_valid, sel, busy, done}
  function automatic logic [5:0] outs();
    return {bus.err, bus.sel_valid, bus.sel, bus.busy, bus.done};
  endfunction

  // One single-shot scan with per-cycle checks. noise toggles start randomly
  // while busy (must be ignored) and scrambles ch_en after the start edge.
  task automatic run_scan(input string name, input logic [3:0] m, input logic [3:0] iv,
                          input logic [3:0] exp_res, input bit noise);
    int         q[$];
    logic [1:0] s;
    int         dones;
    for (int k = 0; k < 4; k++)
      if (m[k]) for (int d = 0; d < DWELL; d++) q.push_back(k);
    mux_i          = iv;
    bus.continuous = 1'b0;
    bus.start      = 1'b1;
    bus.ch_en      = m;
    tick();
    bus.start = 1'b0;
    if (noise) bus.ch_en = 4'($urandom);
    dones = 0;
    for (int c = 1; c <= q.size(); c++) begin
      s = 2'(q[c-1]);
      if (outs() !== {1'b0, 1'b1, s, 1'b1, 1'b0}) dones++;
      if (noise) bus.start = 1'($urandom_range(0, 1));
      tick();
    end
    check({name, " dwell sequence"}, dones, 0);
    bus.start = 1'b0;
    s = 2'(q[q.size()-1]);
    check({name, " done cycle"}, outs(), {1'b0, 1'b0, s, 1'b1, 1'b1});
    check({name, " result"}, bus.result, exp_res);
    tick();
    check({name, " idle after done"}, {outs(), bus.result}, {6'b000000, exp_res});
  endtask

  initial begin
    logic [3:0] m, iv, prior;
    int         dcnt, ecnt, dcyc;

    vecs[0] = '{4'b1111, 4'b1010, 4'b1010};
    vecs[1] = '{4'b0101, 4'b1101, 4'b0101};
    vecs[2] = '{4'b0001, 4'b1111, 4'b0001};
    vecs[3] = '{4'b1000, 4'b1000, 4'b1000};
    vecs[4] = '{4'b0110, 4'b1001, 4'b0000};
    vecs[5] = '{4'b1111, 4'b0000, 4'b0000};

    rst_n          = 1'b0;
    bus.start      = 1'b0;
    bus.ch_en      = 4'b0000;
    bus.continuous = 1'b0;
    bus.abort      = 1'b0;
    tick();
    tick();
    check("reset outputs", {outs(), bus.result}, 10'd0);
    rst_n = 1'b1;
    tick();
    check("idle after reset", {outs(), bus.result}, 10'd0);

    // Table-driven single-shot scans
    for (int i = 0; i < 6; i++)
      run_scan($sformatf("vec%0d", i), vecs[i].ch_en, vecs[i].mux_in, vecs[i].exp_result, 1'b0);

    // Empty mask: one-cycle err, never busy, result untouched
    prior     = bus.result;
    bus.start = 1'b1;
    bus.ch_en = 4'b0000;
    tick();
    bus.start = 1'b0;
    check("err pulse", {outs(), bus.result}, {6'b100000, prior});
    tick();
    check("err cleared", {outs(), bus.result}, {6'b000000, prior});

    // Continuous on channel 3: done every DWELL+1 cycles
    mux_i          = 4'b1010;
    bus.continuous = 1'b1;
    bus.start      = 1'b1;
    bus.ch_en      = 4'b1000;
    tick();
    bus.start = 1'b0;
    bus.ch_en = 4'b0001;
    dcnt = 0;
    for (int c = 1; c <= 15; c++) begin
      if ({bus.done, bus.sel_valid, bus.busy} !== {(c % 5) == 0, (c % 5) != 0, 1'b1}) dcnt++;
      if (c == 5)  check("cont first result", bus.result, 4'b1000);
      if (c == 6)  mux_i = 4'b0010;
      if (c == 10) check("cont second result", bus.result, 4'b0000);
      if (c == 11) bus.continuous = 1'b0;
      tick();
    end
    check("cont timing", dcnt, 0);
    check("cont stop idle", outs(), 6'b000000);

    // Abort in cycle 6: idle next cycle, no done, result kept
    prior     = bus.result;
    mux_i     = 4'b1111;
    bus.start = 1'b1;
    bus.ch_en = 4'b1111;
    tick();
    bus.start = 1'b0;
    for (int c = 1; c < 6; c++) tick();
    bus.abort = 1'b1;
    tick();
    bus.abort = 1'b0;
    check("abort idle", {outs(), bus.result}, {6'b000000, prior});
    dcnt = 0;
    for (int c = 0; c < 20; c++) begin
      dcnt += int'(bus.done) + int'(bus.busy);
      tick();
    end
    check("abort no done", dcnt, 0);

    // Asynchronous reset mid-scan, applied between clock edges
    run_scan("pre-reset", 4'b1111, 4'b0110, 4'b0110, 1'b0);
    bus.start = 1'b1;
    bus.ch_en = 4'b1111;
    tick();
    bus.start = 1'b0;
    for (int c = 1; c < 6; c++) tick();
    #2 rst_n = 1'b0;
    #1;
    check("async reset", {outs(), bus.result}, 10'd0);
    tick();
    rst_n = 1'b1;
    dcnt = 0;
    for (int c = 0; c < 20; c++) begin
      dcnt += int'(bus.done) + int'(bus.busy);
      tick();
    end
    check("post reset quiet", dcnt, 0);

    // start re-pulsed in cycles 3 and 17 of a full scan: both ignored
    mux_i     = 4'b0011;
    bus.start = 1'b1;
    bus.ch_en = 4'b1111;
    tick();
    dcnt = 0; ecnt = 0; dcyc = 0;
    for (int c = 1; c <= 30; c++) begin
      bus.start = (c == 3) || (c == 17);
      if (bus.done) begin dcnt++; dcyc = c; end
      if (bus.err) ecnt++;
      tick();
    end
    bus.start = 1'b0;
    check("restart done count", dcnt, 1);
    check("restart done cycle", dcyc, 4 * DWELL + 1);
    check("restart no err", ecnt, 0);
    check("restart result", bus.result, 4'b0011);

    // One-cycle glitch on the last dwell cycle of channel 1 (cycle 8)
    mux_i     = 4'b1111;
    bus.start = 1'b1;
    bus.ch_en = 4'b1111;
    tick();
    bus.start = 1'b0;
    for (int c = 1; c <= 16; c++) begin
      glitch = (c == 2 * DWELL);
      tick();
    end
    glitch = 1'b0;
`ifdef MUX_SCAN_MAJ_EN
    check("glitch majority", bus.result, 4'b1111);
`else
    check("glitch single sample", bus.result, 4'b1101);
`endif
    tick();

    // Randomized scans against the scan-rule model
    for (int i = 0; i < 40; i++) begin
      m  = 4'($urandom_range(0, 15));
      iv = 4'($urandom);
      if (m == 4'b0000) begin
        prior     = bus.result;
        bus.start = 1'b1;
        bus.ch_en = m;
        tick();
        bus.start = 1'b0;
        check("rand err", {outs(), bus.result}, {6'b100000, prior});
        tick();
      end else begin
        run_scan($sformatf("rand%0d", i), m, iv, iv & m, 1'b1);
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mux_scan_ctrl.md
Name: mux_scan_ctrl

Overview:
Scan controller that sits directly upstream of the 4:1 mux: drives the mux select, dwells on each enabled channel, samples the mux output and packs the samples into a 4-bit result word. It supports single-shot or continuous round-robin scanning, with a start/busy/done handshake toward the system controller.

Parameters:
DWELL, 4, clock cycles spent on each enabled channel (legal 1..15; 3..15 when MUX_SCAN_MAJ_EN is defined)
DWELL_W, 4, width of internal dwell counter; must hold DWELL-1

Ports:
clk  input  1  system clock, rising-edge
rst_n  input  1  asynchronous active-low reset
start  input  1  request a scan; honoured only in IDLE
ch_en  input  4  channel enable mask; bit k enables mux input k; latched on accepted start
continuous  input  1  re-scan automatically after each done; sampled in DONE state only
abort  input  1  terminate scan; return to IDLE
y  input  1  mux output (Y)
sel  output  2  mux select (S)
sel_valid  output  1  sel is driving an active scan channel
busy  output  1  high in DWELL and DONE states
done  output  1  one-cycle pulse; result updated this cycle
err  output  1  one-cycle pulse; start accepted with ch_en == 4'b0000
result  output  4  bit k = sampled y for channel k; disabled channels read 0

Behaviour:
- Reset (async, rst_n low): state=IDLE, sel=2'b00, sel_valid=0, busy=0, done=0, err=0, result=4'b0000, latched mask=0, dwell counter=0, shadow=0.
- States: IDLE, DWELL, DONE.
- IDLE: sel=2'b00, sel_valid=0. On start:
  - ch_en==0: err=1 for the next cycle; stay IDLE.
  - otherwise: latch ch_en, clear shadow, set ch = lowest enabled index, counter=0, go DWELL.
- DWELL: sel=ch, sel_valid=1; counter increments each cycle.
  - When counter==DWELL-1, y is sampled on that clock edge into shadow[ch].
  - Next enabled index above ch exists: move to it, counter=0, stay DWELL.
  - Otherwise go DONE; result <= shadow including the final sample, on the same edge.
- DONE (1 cycle): done=1, busy=1, sel_valid=0, sel holds last channel.
  - continuous=1: ch = lowest enabled index of the latched mask, counter=0, go DWELL.
  - continuous=0: go IDLE.
  - The mask is not re-latched during continuous scanning.
- Latency: with N enabled channels, the start edge is edge 0 and done is high in cycle N*DWELL+1. Continuous period is N*DWELL+1 cycles.
- Disabled channels are skipped with zero cycles; sel never shows a disabled index while sel_valid=1.
- start while busy: ignored, no err.
- abort (DWELL or DONE): go IDLE on the next edge. No done; result unchanged; shadow discarded. abort has priority over every other transition.
- abort and start together in IDLE: start wins.
- rst_n low mid-scan: immediate return to reset values; no done pulse.

Optional Feature:
MUX_SCAN_MAJ_EN
- Defined: y is sampled on the last three dwell cycles (counter = DWELL-3, DWELL-2, DWELL-1). shadow[ch] = majority of the three samples, for glitch rejection. DWELL must be >= 3.
- Undefined: single sample on the last dwell cycle only. Timing of sel/done is identical in both builds.

Test Plan:
1. DWELL=4, ch_en=1111, mux I=4'b1010, start pulse -> sel 0,1,2,3 for 4 cycles each, sel_valid=1 throughout; done in cycle 17; result=4'b1010; busy falls after done.
2. ch_en=0101, I=4'b1101 -> sel shows only 0 then 2; done in cycle 9; result=4'b0101.
3. ch_en=0000, start -> err pulse 1 cycle; busy stays 0; result unchanged.
4. continuous=1, ch_en=1000, I=4'b1010 -> done every 5 cycles, first result=4'b1000. Change I to 4'b0010 -> next result=4'b0000. Drop continuous -> returns to IDLE after the following done.
5. ch_en=1111, abort in cycle 6 -> IDLE next cycle, no done, result holds its prior value. Repeat with rst_n low in cycle 6 -> all outputs reset immediately and asynchronously.
6. start re-pulsed in cycles 3 and 17 of a ch_en=1111 scan -> both ignored; exactly one done; err never asserts. With MUX_SCAN_MAJ_EN defined, a 1-cycle y glitch on the last dwell cycle does not change that channel's result bit.
